octal_rr_arbiter: RTL and testbench

Eight-input round-robin arbiter that grants exactly one of eight request lines at a time. It drives a registered one-hot grant vector straight into the 8-to-3 octal-to-binary encoder, so the encoder input is always one-hot or all-zero. A hold-timeout counter bounds how long any single requester keeps the grant.

---
 rtl/octal_rr_arbiter.sv | 115 +++++++++++
 tb/tb_octal_rr_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/octal_rr_arbiter.sv
// Eight-input round-robin arbiter with a registered one-hot grant and a
// hold-timeout that bounds how long any single requester keeps the grant.
module octal_rr_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int unsigned N  = 8;
    localparam int unsigned PW = 3;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic          TO_EN    = (TIMEOUT != 0);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic          gnt_valid_q, gnt_valid_d;
    logic          timeout_q, timeout_d;

    logic [PW-1:0] cand;
    logic [PW-1:0] pick;
    logic          hit_limit;
    logic          release_now;

    // Rotating priority search: walk downward so the lowest offset from ptr wins.
    always_comb begin
        cand = '0;
        pick = ptr_q;
        for (int i = N - 1; i >= 0; i--) begin
            cand = ptr_q + PW'(i);
            if (req[cand]) begin
                pick = cand;
            end
        end
    end

    assign hit_limit   = TO_EN && (cnt_q == CNT_LAST);
    assign release_now = done || !req[idx_q] || hit_limit;

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    idx_d       = pick;
                    gnt_d       = N'(1) << pick;
                    gnt_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    timeout_d   = hit_limit;
                    ptr_d       = idx_q + PW'(1);
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_octal_rr_arbiter.sv
// Scoreboard bench for octal_rr_arbiter: each driven cycle pushes the expected
// {gnt, gnt_valid, timeout} and a monitor compares it just after the next edge.
module tb_octal_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic       timeout;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    typedef struct packed {
        logic [7:0] gnt;
        logic       vld;
        logic       to;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];

    octal_rr_arbiter #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus on the falling edge and queue the outcome of the next rising edge.
    task automatic step(input logic rst, input logic [7:0] r, input logic d,
                        input logic [7:0] eg, input logic eto, input string tag);
        exp_t e;
        @(negedge clk);
        rst_n = rst;
        req   = r;
        done  = d;
        e.gnt = eg;
        e.vld = |eg;
        e.to  = eto;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() != 0) begin
            exp_t  e;
            string t;
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            check(t, 32'({gnt, gnt_valid, timeout}), 32'(e));
        end
    end

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;

        // Reset held with all requests asserted.
        for (int i = 0; i < 3; i++) step(1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, "reset");
        step(1'b1, 8'hFF, 1'b0, 8'h01, 1'b0, "first_grant");

        // Full round-robin rotation with a zero cycle between grants.
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, "rr_release");
            step(1'b1, 8'hFF, 1'b0, 8'(8'h01 << (k % 8)), 1'b0, "rr_grant");
        end
        step(1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, "rr_release");

        // Withdrawal from ptr=1: grant bit 2, drop it, next search starts at 3.
        step(1'b1, 8'h04, 1'b0, 8'h04, 1'b0, "wd_grant");
        step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, "wd_release");
        step(1'b1, 8'hFF, 1'b0, 8'h08, 1'b0, "wd_ptr3");
        step(1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, "wd_done");

        // Pointer wrap after serving bit 6.
        step(1'b1, 8'h40, 1'b0, 8'h40, 1'b0, "wrap_g6");
        step(1'b1, 8'h40, 1'b1, 8'h00, 1'b0, "wrap_rel");
        step(1'b1, 8'h41, 1'b0, 8'h01, 1'b0, "wrap_to0");
        step(1'b1, 8'h41, 1'b1, 8'h00, 1'b0, "wrap_rel");
        step(1'b1, 8'h40, 1'b0, 8'h40, 1'b0, "wrap_g6b");
        step(1'b1, 8'h40, 1'b1, 8'h00, 1'b0, "wrap_rel");
        step(1'b1, 8'h81, 1'b0, 8'h80, 1'b0, "wrap_g7");
        step(1'b1, 8'h81, 1'b1, 8'h00, 1'b0, "wrap_rel");

        // Timeout with TIMEOUT=4: four cycles high, pulse, re-grant.
        for (int i = 0; i < 4; i++) step(1'b1, 8'h10, 1'b0, 8'h10, 1'b0, "to_hold");
        step(1'b1, 8'h10, 1'b0, 8'h00, 1'b1, "to_pulse");
        step(1'b1, 8'h10, 1'b0, 8'h10, 1'b0, "to_regrant");
        for (int i = 0; i < 3; i++) step(1'b1, 8'h10, 1'b0, 8'h10, 1'b0, "to_hold2");
        step(1'b1, 8'h10, 1'b1, 8'h00, 1'b1, "to_with_done");
        step(1'b1, 8'h00, 1'b1, 8'h00, 1'b0, "idle_done_ignored");
        step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, "idle_quiet");

        // Mid-grant reset clears the pointer (ptr is 5 here before reset).
        step(1'b1, 8'h20, 1'b0, 8'h20, 1'b0, "mr_grant");
        step(1'b0, 8'h20, 1'b0, 8'h00, 1'b0, "mr_reset");
        step(1'b1, 8'h21, 1'b0, 8'h01, 1'b0, "mr_ptr0");

        // Request changes during GRANT do not move the grant.
        step(1'b1, 8'h23, 1'b0, 8'h01, 1'b0, "hold_stable");
        step(1'b1, 8'h23, 1'b1, 8'h00, 1'b0, "hold_rel");
        step(1'b1, 8'h23, 1'b0, 8'h02, 1'b0, "hold_next");
        step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, "final_withdraw");

        repeat (3) @(posedge clk);
        #2;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
